multicycle_control_fsm: RTL and testbench

//  Multi-cycle sequencer for the RV32 core datapath: walks each instruction through

---
 rtl/multicycle_control_fsm_pkg.sv | 62 ++++++
 rtl/multicycle_control_fsm_r_type_alu_decoder.sv | 25 ++
 rtl/multicycle_control_fsm.sv | 157 +++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared encodings for the multi-cycle RV32 control sequencer: opcodes, ALU codes,
// funct keys, FSM states and instruction classes.
package multicycle_control_fsm_pkg;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  // R-type keys are {funct_7_5, funct3}
  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b1000;
  localparam logic [3:0] FN_AND = 4'b0111;
  localparam logic [3:0] FN_OR  = 4'b0110;
  localparam logic [3:0] FN_SLL = 4'b0001;
  localparam logic [3:0] FN_SRL = 4'b0101;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE = 3'd0,
    CLS_R    = 3'd1,
    CLS_LW   = 3'd2,
    CLS_SW   = 3'd3,
    CLS_BEQ  = 3'd4,
    CLS_ILL  = 3'd5
  } class_e;

  function automatic class_e decode_class(input logic [6:0] opcode,
                                          input logic [2:0] funct3,
                                          input logic       r_legal);
    class_e c;
    case (opcode)
      OPC_R:   c = r_legal ? CLS_R : CLS_ILL;
      OPC_LW:  c = (funct3 == F3_LW)  ? CLS_LW  : CLS_ILL;
      OPC_SW:  c = (funct3 == F3_SW)  ? CLS_SW  : CLS_ILL;
      OPC_BEQ: c = (funct3 == F3_BEQ) ? CLS_BEQ : CLS_ILL;
      default: c = CLS_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_control_fsm_r_type_alu_decoder.sv
// Combinational R-type decoder: {funct_7_5, funct3} -> ALU operation plus a legal bit.
module r_type_alu_decoder
  import multicycle_control_fsm_pkg::*;
(
  input  logic       funct_7_5,
  input  logic [2:0] funct3,
  output logic [3:0] alu_operation,
  output logic       legal
);

  always_comb begin
    alu_operation = ALU_ADD;
    legal         = 1'b1;
    case ({funct_7_5, funct3})
      FN_ADD:  alu_operation = ALU_ADD;
      FN_SUB:  alu_operation = ALU_SUB;
      FN_AND:  alu_operation = ALU_AND;
      FN_OR:   alu_operation = ALU_OR;
      FN_SLL:  alu_operation = ALU_SLL;
      FN_SRL:  alu_operation = ALU_SRL;
      default: legal         = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32 control sequencer (FETCH/DECODE/EXEC/MEM/WB) with req/ack memories.
// Optional MEM_TIMEOUT_EN adds a bounded ack wait that traps into a sticky HALT state.
module multicycle_control_fsm
  import multicycle_control_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct_7_5,
  input  logic       alu_zero,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_src,
  output logic       alu_src,
  output logic       wb_sel,
  output logic       reg_write,
  output logic [3:0] alu_operation,
  output logic       illegal_instr,
  output logic       mem_fault,
  output state_e     fsm_state
);

  state_e     state_q, state_d;
  class_e     class_q, dec_class;
  logic [3:0] r_op;
  logic       r_legal;
  logic       expired;

  r_type_alu_decoder u_r_dec (
    .funct_7_5     (funct_7_5),
    .funct3        (funct3),
    .alu_operation (r_op),
    .legal         (r_legal)
  );

  assign dec_class = decode_class(opcode, funct3, r_legal);
  assign fsm_state = state_q;

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_q;
  logic          waiting;

  // Any non-waiting cycle clears the count, so entry to FETCH/MEM always starts at zero.
  assign waiting = ((state_q == ST_FETCH) && !imem_ack) ||
                   ((state_q == ST_MEM)   && !dmem_ack);
  assign expired = waiting && (wait_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n)       wait_q <= '0;
    else if (waiting) wait_q <= wait_q + 1'b1;
    else              wait_q <= '0;
  end

  assign mem_fault = (state_q == ST_HALT);
`else
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign expired        = 1'b0;
  assign mem_fault      = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      class_q <= CLS_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) class_q <= dec_class;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = ST_FETCH;
      ST_FETCH: begin
        if (imem_ack)     state_d = ST_DECODE;
        else if (expired) state_d = ST_HALT;
      end
      ST_DECODE: state_d = (dec_class == CLS_ILL) ? ST_FETCH : ST_EXEC;
      ST_EXEC: begin
        case (class_q)
          CLS_R:          state_d = ST_WB;
          CLS_LW, CLS_SW: state_d = ST_MEM;
          default:        state_d = ST_FETCH;
        endcase
      end
      ST_MEM: begin
        if (dmem_ack)     state_d = (class_q == CLS_LW) ? ST_WB : ST_FETCH;
        else if (expired) state_d = ST_HALT;
      end
      ST_WB:     state_d = ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    imem_req      = 1'b0;
    dmem_req      = 1'b0;
    dmem_we       = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_src        = 1'b0;
    alu_src       = 1'b0;
    wb_sel        = 1'b0;
    reg_write     = 1'b0;
    alu_operation = ALU_ADD;
    illegal_instr = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = 1'b1;
        ir_write = imem_ack;
      end
      // The class is not latched yet here, so the live decode drives the illegal retire.
      ST_DECODE: begin
        if (dec_class == CLS_ILL) begin
          illegal_instr = 1'b1;
          pc_write      = 1'b1;
        end
      end
      ST_EXEC: begin
        case (class_q)
          CLS_R:          alu_operation = r_op;
          CLS_LW, CLS_SW: alu_src = 1'b1;
          CLS_BEQ: begin
            alu_operation = ALU_SUB;
            pc_write      = 1'b1;
            pc_src        = alu_zero;
          end
          default: ;
        endcase
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (class_q == CLS_SW);
        pc_write = (class_q == CLS_SW) && dmem_ack;
      end
      ST_WB: begin
        reg_write = 1'b1;
        wb_sel    = (class_q == CLS_LW);
        pc_write  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: directed instructions with a retire scoreboard,
// reset-mid-handshake and ack-wait checks (MEM_TIMEOUT_EN selects the timeout branch).
module tb_multicycle_control_fsm;
  import multicycle_control_fsm_pkg::*;

  localparam int W = 21;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        alu_zero, imem_ack, dmem_ack;
  logic        imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src;
  logic        alu_src, wb_sel, reg_write, illegal_instr, mem_fault;
  logic [3:0]  alu_operation;
  state_e      fsm_state;

  logic [W-1:0] exp_q[$];
  int n_tests    = 0;
  int n_fail     = 0;
  int retire_cnt = 0;
  int dmem_delay = 0;
  int dwait      = 0;
  bit resp_en    = 1'b1;

  multicycle_control_fsm #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (instr[6:0]),
    .funct3        (instr[14:12]),
    .funct_7_5     (instr[30]),
    .alu_zero      (alu_zero),
    .imem_ack      (imem_ack),
    .dmem_ack      (dmem_ack),
    .imem_req      (imem_req),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_src        (pc_src),
    .alu_src       (alu_src),
    .wb_sel        (wb_sel),
    .reg_write     (reg_write),
    .alu_operation (alu_operation),
    .illegal_instr (illegal_instr),
    .mem_fault     (mem_fault),
    .fsm_state     (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Retire record: {cycles, exec alu_op, exec alu_src, pc_src, reg_write count,
  // wb_sel, illegal seen, dmem_req cycles, dmem_we}
  function automatic logic [W-1:0] rec(input int cyc, input logic [3:0] op,
                                       input logic src, input logic pcs, input int rw,
                                       input logic wbs, input logic ill, input int dreq,
                                       input logic dwe);
    return {6'(cyc), op, src, pcs, 2'(rw), wbs, ill, 4'(dreq), dwe};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // data memory responder: ack after dmem_delay wait cycles
  always @(negedge clk) begin
    if (resp_en) begin
      if (dmem_req) begin
        dmem_ack = (dwait == dmem_delay);
        dwait++;
      end else begin
        dmem_ack = 1'b0;
        dwait    = 0;
      end
    end
  end

  // monitor / scoreboard: one record per pc_write
  bit           m_started = 1'b0;
  int           m_cyc, m_rw, m_dreq;
  logic [3:0]   m_op;
  logic         m_src, m_wbs, m_ill, m_dwe;
  logic [W-1:0] m_got, m_exp;

  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      m_started = 1'b0;
    end else begin
      if (imem_req && !m_started) begin
        m_started = 1'b1;
        m_cyc = 0; m_rw = 0; m_dreq = 0;
        m_op = 4'hF; m_src = 1'b0; m_wbs = 1'b0; m_ill = 1'b0; m_dwe = 1'b0;
      end
      if (m_started) begin
        m_cyc++;
        if (fsm_state == ST_EXEC) begin
          m_op  = alu_operation;
          m_src = alu_src;
        end
        if (reg_write) begin
          m_rw++;
          m_wbs = wb_sel;
        end
        if (illegal_instr) m_ill = 1'b1;
        if (dmem_req) begin
          m_dreq++;
          m_dwe = dmem_we;
        end
      end
      if (pc_write) begin
        m_got = rec(m_cyc, m_op, m_src, pc_src, m_rw, m_wbs, m_ill, m_dreq, m_dwe);
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL retire_unexpected: got record %h, no retire expected", m_got);
        end else begin
          m_exp = exp_q.pop_front();
          if (m_got !== m_exp) begin
            n_fail++;
            $display("FAIL retire_%0d: got record %h (cycles %0d) expected %h (cycles %0d)",
                     retire_cnt, m_got, m_got[W-1 -: 6], m_exp, m_exp[W-1 -: 6]);
          end
        end
        m_started = 1'b0;
        retire_cnt++;
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [31:0] ins, input logic z, input int dly,
                       input logic [W-1:0] e);
    instr      = ins;
    alu_zero   = z;
    dmem_delay = dly;
    exp_q.push_back(e);
  endtask

  task automatic wait_retire(input string name);
    int start = retire_cnt;
    bit done  = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      #3;
      if (retire_cnt != start) done = 1'b1;
    end
    check({name, "_retire_seen"}, 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input string name, input logic [31:0] ins, input logic z,
                     input int dly, input logic [W-1:0] e);
    issue(ins, z, dly, e);
    wait_retire(name);
  endtask

  initial begin
    bit seen;
    instr    = 32'h0;
    alu_zero = 1'b0;
    imem_ack = 1'b1;
    dmem_ack = 1'b0;
    rst_n    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctrl_outputs",
          {imem_req, dmem_req, dmem_we, ir_write, pc_write, pc_src, alu_src, wb_sel,
           reg_write, illegal_instr, mem_fault}, 32'd0);
    check("reset_alu_operation", alu_operation, 32'h2);
    check("reset_state", fsm_state, ST_IDLE);

    // add x3,x1,x2 right out of reset
    issue(32'h002081B3, 1'b0, 0, rec(4, 4'b0010, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    check("release_idle_req", imem_req, 32'd0);
    @(negedge clk); #1;
    check("release_fetch_req", imem_req, 32'd1);
    wait_retire("add");

    run("sub",  32'h402081B3, 1'b0, 0, rec(4, 4'b0110, 0, 0, 1, 0, 0, 0, 0));
    run("sll",  32'h002091B3, 1'b0, 0, rec(4, 4'b1000, 0, 0, 1, 0, 0, 0, 0));
    run("srl",  32'h0020D1B3, 1'b0, 0, rec(4, 4'b1001, 0, 0, 1, 0, 0, 0, 0));
    run("and",  32'h0020F1B3, 1'b0, 0, rec(4, 4'b0000, 0, 0, 1, 0, 0, 0, 0));
    run("or",   32'h0020E1B3, 1'b0, 0, rec(4, 4'b0001, 0, 0, 1, 0, 0, 0, 0));
    run("xor_ill", 32'h0020C1B3, 1'b0, 0, rec(2, 4'hF, 0, 0, 0, 0, 1, 0, 0));
    run("sra_ill", 32'h4020D1B3, 1'b0, 0, rec(2, 4'hF, 0, 0, 0, 0, 1, 0, 0));
    run("lw_d3",   32'h0000A183, 1'b0, 3, rec(8, 4'b0010, 1, 0, 1, 1, 0, 4, 0));
    run("lw_d0",   32'h0000A183, 1'b0, 0, rec(5, 4'b0010, 1, 0, 1, 1, 0, 1, 0));
    run("sw_d0",   32'h0020A023, 1'b0, 0, rec(4, 4'b0010, 1, 0, 0, 0, 0, 1, 1));
    run("sw_d2",   32'h0020A023, 1'b0, 2, rec(6, 4'b0010, 1, 0, 0, 0, 0, 3, 1));
    run("beq_z1",  32'h00208063, 1'b1, 0, rec(3, 4'b0110, 0, 1, 0, 0, 0, 0, 0));
    run("beq_z0",  32'h00208063, 1'b0, 0, rec(3, 4'b0110, 0, 0, 0, 0, 0, 0, 0));
    run("bne_ill", 32'h00209063, 1'b0, 0, rec(2, 4'hF, 0, 0, 0, 0, 1, 0, 0));
    run("lb_ill",  32'h00008183, 1'b0, 0, rec(2, 4'hF, 0, 0, 0, 0, 1, 0, 0));
    run("addi_ill", 32'h00000013, 1'b0, 0, rec(2, 4'hF, 0, 0, 0, 0, 1, 0, 0));

    // reset in the middle of a load's data wait, then a stale ack
    resp_en  = 1'b0;
    dmem_ack = 1'b0;
    instr    = 32'h0000A183;
    seen     = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk); #1;
      if (dmem_req) seen = 1'b1;
    end
    check("mem_wait_reached", 32'(seen), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    check("rst_mid_mem_req", dmem_req, 32'd0);
    check("rst_mid_mem_state", fsm_state, ST_IDLE);
    dmem_ack = 1'b1;
    imem_ack = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); #1;
      check($sformatf("late_ack_%0d", k), {reg_write, pc_write, dmem_req, ir_write}, 32'd0);
    end
    dmem_ack = 1'b0;
    resp_en  = 1'b1;

    // imem_ack stuck low for 16 wait cycles
    @(posedge clk); #1;
    rst_n = 1'b0;
    instr = 32'h002081B3;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk); #1;
      check($sformatf("stuck_wait_%0d", k), {mem_fault, imem_req}, 32'b01);
      @(posedge clk);
    end
    @(negedge clk); #1;
`ifdef MEM_TIMEOUT_EN
    check("timeout_fault", {mem_fault, imem_req, ir_write, pc_write}, 32'b1000);
    check("timeout_state", fsm_state, ST_HALT);
    imem_ack = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("halt_sticky", {mem_fault, imem_req, reg_write, pc_write}, 32'b1000);
`else
    check("no_timeout_still_waiting", {mem_fault, imem_req}, 32'b01);
`endif

    // ack arriving on the 16th wait cycle still completes normally
    @(posedge clk); #1;
    rst_n    = 1'b0;
    imem_ack = 1'b0;
    issue(32'h002081B3, 1'b0, 0, rec(19, 4'b0010, 0, 0, 1, 0, 0, 0, 0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1;
    imem_ack = 1'b1;
    wait_retire("ack_on_16");
    @(negedge clk); #1;
    check("ack_on_16_no_fault", mem_fault, 32'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
